// File: rtl/fetch_sequencer_pkg.sv
// Shared types and default constants for the instruction fetch sequencer.
package fetch_sequencer_pkg;

  localparam logic [15:0] DEF_RESET_PC  = 16'h0000;
  localparam logic [15:0] DEF_NOP_INSTR = 16'h0800;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    HALT  = 2'd3
  } fetchState_t;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Instruction memory port: read strobe/address out, stall/done/data back.
interface fetch_sequencer_if;
  logic        memRd;
  logic [15:0] memAddr;
  logic        memStall;
  logic        memDone;
  logic [15:0] memInstr;

  modport master (output memRd, memAddr, input memStall, memDone, memInstr);
  modport slave  (input memRd, memAddr, output memStall, memDone, memInstr);
endinterface

// File: rtl/fetch_hold_buf.sv
// One-entry {instr, pc} buffer parking a fetch that completes while IF/ID is stalled.
module fetch_hold_buf (
  input  logic        clk,
  input  logic        rst,
  input  logic        capture,
  input  logic        drain,
  input  logic        flush,
  input  logic [15:0] instrIn,
  input  logic [15:0] pcIn,
  output logic        full,
  output logic [15:0] instrHeld,
  output logic [15:0] pcHeld
);
  always_ff @(posedge clk) begin
    if (rst)                 full <= 1'b0;
    else if (flush || drain) full <= 1'b0;
    else if (capture)        full <= 1'b1;
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      instrHeld <= instrIn;
      pcHeld    <= pcIn;
    end
  end
endmodule

// File: rtl/rca_16b.sv
// 16-bit ripple-carry adder, modulo 2^16 (carry out discarded).
module rca_16b (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] sum
);
  always_comb begin
    logic carry;
    carry = 1'b0;
    sum   = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      sum[i] = a[i] ^ b[i] ^ carry;
      carry  = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
  end
endmodule

// File: rtl/fetch_sequencer.sv
// Owns the PC, sequences fetches over the stalling memory port and presents
// a registered {instr, PC, PC+2, valid} bundle to IF/ID.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter logic [15:0] RESET_PC  = DEF_RESET_PC,
  parameter logic [15:0] NOP_INSTR = DEF_NOP_INSTR
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               redirect,
  input  logic [15:0]        redirectPC,
  input  logic               halt,
  fetch_sequencer_if.master  mem,
  output logic [15:0]        instrOut,
  output logic [15:0]        instrPC,
  output logic [15:0]        pcPlus2,
  output logic               instrValid,
  output logic               halted,
  output logic               misalignErr
);
  fetchState_t state, stateNext;
  logic [15:0] pc, pcNext, reqPC, reqPCNext;
  logic        squash, squashNext;
  logic        loadOut, clearOut, goHalt, misalignNext;
  logic        capture, drain, flush;
  logic        bufFull;
  logic [15:0] bufInstr, bufPC;
  logic [15:0] loadInstr, loadPC, loadPCPlus2;
  logic        memRd;
  logic [15:0] memAddr;

  assign mem.memRd   = memRd;
  assign mem.memAddr = memAddr;

  fetch_hold_buf holdBuf (
    .clk      (clk),
    .rst      (rst),
    .capture  (capture),
    .drain    (drain),
    .flush    (flush),
    .instrIn  (mem.memInstr),
    .pcIn     (reqPC),
    .full     (bufFull),
    .instrHeld(bufInstr),
    .pcHeld   (bufPC)
  );

  // Source of the bundle being loaded: live hit, completed miss, or parked entry.
  always_comb begin
    loadInstr = mem.memInstr;
    loadPC    = pc;
    unique case (state)
      WAIT:    loadPC = reqPC;
      HOLD:    begin loadPC = bufPC; loadInstr = bufInstr; end
      default: loadPC = pc;
    endcase
  end

  rca_16b incAdder (
    .a  (loadPC),
    .b  (16'd2),
    .sum(loadPCPlus2)
  );

  always_comb begin
    stateNext    = state;
    pcNext       = pc;
    reqPCNext    = reqPC;
    squashNext   = squash;
    loadOut      = 1'b0;
    clearOut     = 1'b0;
    goHalt       = 1'b0;
    misalignNext = 1'b0;
    capture      = 1'b0;
    drain        = 1'b0;
    flush        = 1'b0;
    memAddr      = (state == WAIT || state == HOLD) ? reqPC : pc;
    memRd        = (state == FETCH) & ~stall & ~redirect & ~rst;

    if (state != HALT && redirect) begin
      clearOut = 1'b1;
      if (redirectPC[0]) begin
        goHalt       = 1'b1;
        misalignNext = 1'b1;
        stateNext    = HALT;
      end else begin
        pcNext = redirectPC;
        unique case (state)
          // A miss completing in the redirect cycle needs no squash.
          WAIT: begin
            squashNext = ~mem.memDone;
            stateNext  = mem.memDone ? FETCH : WAIT;
          end
          HOLD: begin
            flush     = 1'b1;
            stateNext = FETCH;
          end
          default: stateNext = FETCH;
        endcase
      end
    end else if (state != HALT && halt && !stall) begin
      goHalt    = 1'b1;
      stateNext = HALT;
    end else begin
      unique case (state)
        FETCH: begin
          if (!stall) begin
            if (mem.memDone) begin
              loadOut = 1'b1;
              pcNext  = loadPCPlus2;
            end else if (mem.memStall) begin
              reqPCNext = pc;
              stateNext = WAIT;
            end
          end
        end
        WAIT: begin
          if (mem.memDone) begin
            if (squash) begin
              squashNext = 1'b0;
              stateNext  = FETCH;
            end else if (stall) begin
              capture   = 1'b1;
              stateNext = HOLD;
            end else begin
              loadOut   = 1'b1;
              pcNext    = loadPCPlus2;
              stateNext = FETCH;
            end
          end
        end
        HOLD: begin
          if (!stall && bufFull) begin
            loadOut   = 1'b1;
            drain     = 1'b1;
            pcNext    = loadPCPlus2;
            stateNext = FETCH;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FETCH;
      pc          <= RESET_PC;
      reqPC       <= RESET_PC;
      squash      <= 1'b0;
      instrValid  <= 1'b0;
      instrOut    <= NOP_INSTR;
      instrPC     <= '0;
      pcPlus2     <= '0;
      halted      <= 1'b0;
      misalignErr <= 1'b0;
    end else begin
      state       <= stateNext;
      pc          <= pcNext;
      reqPC       <= reqPCNext;
      squash      <= squashNext;
      misalignErr <= misalignNext;
      if (goHalt) halted <= 1'b1;
      // An unstalled IF/ID consumes every cycle, so no new load means a bubble.
      if (loadOut) begin
        instrOut   <= loadInstr;
        instrPC    <= loadPC;
        pcPlus2    <= loadPCPlus2;
        instrValid <= 1'b1;
      end else if (clearOut || !stall || state == HALT) begin
        instrValid <= 1'b0;
        instrOut   <= NOP_INSTR;
      end
    end
  end
endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: expected fetch addresses and IF/ID bundles
// are queued with the stimulus and popped by a negedge monitor.
module tb_fetch_sequencer;
  typedef struct packed {
    logic [15:0] instr;
    logic [15:0] pc;
    logic [15:0] pcp2;
  } instrExp_t;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [15:0] redirectPC;
  logic        halt;
  logic [15:0] instrOut, instrPC, pcPlus2;
  logic        instrValid, halted, misalignErr;

  int total = 0;
  int bad   = 0;

  logic [15:0] reqQ[$];
  instrExp_t   instrQ[$];
  logic [15:0] expAddr;
  instrExp_t   expI;

  fetch_sequencer_if memBus ();

  fetch_sequencer #(
    .RESET_PC (16'h0000),
    .NOP_INSTR(16'h0800)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .redirect   (redirect),
    .redirectPC (redirectPC),
    .halt       (halt),
    .mem        (memBus),
    .instrOut   (instrOut),
    .instrPC    (instrPC),
    .pcPlus2    (pcPlus2),
    .instrValid (instrValid),
    .halted     (halted),
    .misalignErr(misalignErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (memBus.memRd === 1'b1) begin
        total++;
        if (reqQ.size() == 0) begin
          bad++;
          $display("FAIL memReq: got read at %h expected no read", memBus.memAddr);
        end else begin
          expAddr = reqQ.pop_front();
          if (memBus.memAddr !== expAddr) begin
            bad++;
            $display("FAIL memReq: got addr %h expected %h", memBus.memAddr, expAddr);
          end
        end
      end
      if (instrValid === 1'b1 && stall === 1'b0) begin
        total++;
        if (instrQ.size() == 0) begin
          bad++;
          $display("FAIL ifid: got instr %h pc %h expected no valid instr", instrOut, instrPC);
        end else begin
          expI = instrQ.pop_front();
          if (instrOut !== expI.instr || instrPC !== expI.pc || pcPlus2 !== expI.pcp2) begin
            bad++;
            $display("FAIL ifid: got %h/%h/%h expected %h/%h/%h",
                     instrOut, instrPC, pcPlus2, expI.instr, expI.pc, expI.pcp2);
          end
        end
      end
    end
  end

  task automatic expReq(input logic [15:0] a);
    reqQ.push_back(a);
  endtask

  task automatic expInstr(input logic [15:0] i, input logic [15:0] p, input logic [15:0] p2);
    instrExp_t e;
    e.instr = i;
    e.pc    = p;
    e.pcp2  = p2;
    instrQ.push_back(e);
  endtask

  // Apply one cycle of inputs, then advance to just after the next rising edge.
  task automatic cyc(input logic st, input logic rd, input logic [15:0] rpc, input logic hl,
                     input logic ms, input logic md, input logic [15:0] mi);
    stall            = st;
    redirect         = rd;
    redirectPC       = rpc;
    halt             = hl;
    memBus.memStall  = ms;
    memBus.memDone   = md;
    memBus.memInstr  = mi;
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst             = 1'b1;
    stall           = 1'b0;
    redirect        = 1'b0;
    redirectPC      = 16'h0000;
    halt            = 1'b0;
    memBus.memStall = 1'b0;
    memBus.memDone  = 1'b0;
    memBus.memInstr = 16'h0000;
    #4;
    chk("rstMemRd", {15'd0, memBus.memRd}, 16'h0000);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rstValid", {15'd0, instrValid}, 16'h0000);
    chk("rstInstr", instrOut, 16'h0800);
    chk("rstInstrPC", instrPC, 16'h0000);
    chk("rstPcPlus2", pcPlus2, 16'h0000);
    chk("rstHalted", {15'd0, halted}, 16'h0000);
    chk("rstMisalign", {15'd0, misalignErr}, 16'h0000);
    chk("rstPC", memBus.memAddr, 16'h0000);
  endtask

  initial begin
    doReset();

    // Zero-wait hits
    expReq(16'h0000); expInstr(16'h1111, 16'h0000, 16'h0002);
    cyc(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 16'h1111);
    expReq(16'h0002); expInstr(16'h2222, 16'h0002, 16'h0004);
    cyc(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 16'h2222);
    expReq(16'h0004); expInstr(16'h3333, 16'h0004, 16'h0006);
    cyc(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 16'h3333);

    // Three-cycle miss at 0006
    expReq(16'h0006);
    cyc(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 16'h0);
    chk("waitAddr0", memBus.memAddr, 16'h0006);
    cyc(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 16'h0);
    chk("waitAddr1", memBus.memAddr, 16'h0006);
    cyc(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 16'h0);
    chk("waitAddr2", memBus.memAddr, 16'h0006);
    expInstr(16'hA5A5, 16'h0006, 16'h0008);
    cyc(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 16'hA5A5);

    // Redirect during a miss squashes the returning fetch
    expReq(16'h0008);
    cyc(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 16'h0);
    cyc(1'b0, 1'b1, 16'h0040, 1'b0, 1'b1, 1'b0, 16'h0);
    cyc(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 16'hBEEF);
    chk("squashValid", {15'd0, instrValid}, 16'h0000);
    chk("squashNop", instrOut, 16'h0800);
    chk("redirAddr", memBus.memAddr, 16'h0040);
    expReq(16'h0040); expInstr(16'h4040, 16'h0040, 16'h0042);
    cyc(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 16'h4040);

    // Miss completes under stall, parks, releases after stall drops
    expReq(16'h0042);
    cyc(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 16'h0);
    cyc(1'b1, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 16'h0);
    cyc(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 16'h1234);
    cyc(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0);
    chk("holdValid", {15'd0, instrValid}, 16'h0000);
    cyc(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0);
    chk("holdInstr", instrOut, 16'h0800);
    expInstr(16'h1234, 16'h0042, 16'h0044);
    cyc(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0);
    chk("holdPC", memBus.memAddr, 16'h0044);

    // HALT freezes the sequencer; redirect is ignored
    expReq(16'h0044); expInstr(16'h0F0F, 16'h0044, 16'h0046);
    cyc(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 16'h0F0F);
    expReq(16'h0046);
    cyc(1'b0, 1'b0, 16'h0, 1'b1, 1'b0, 1'b1, 16'hDEAD);
    chk("haltFlag", {15'd0, halted}, 16'h0001);
    chk("haltValid", {15'd0, instrValid}, 16'h0000);
    cyc(1'b0, 1'b1, 16'h0080, 1'b0, 1'b0, 1'b0, 16'h0);
    cyc(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 16'h9999);
    chk("haltPC", memBus.memAddr, 16'h0046);
    chk("haltStay", {15'd0, halted}, 16'h0001);

    // Misaligned redirect
    doReset();
    cyc(1'b0, 1'b1, 16'h0041, 1'b0, 1'b0, 1'b0, 16'h0);
    chk("misPulse", {15'd0, misalignErr}, 16'h0001);
    chk("misHalted", {15'd0, halted}, 16'h0001);
    chk("misPC", memBus.memAddr, 16'h0000);
    cyc(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0);
    chk("misPulseEnd", {15'd0, misalignErr}, 16'h0000);
    chk("misHaltStay", {15'd0, halted}, 16'h0001);

    // PC wrap at FFFE and stray memDone in FETCH
    doReset();
    cyc(1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0, 16'h0);
    expReq(16'hFFFE); expInstr(16'h7777, 16'hFFFE, 16'h0000);
    cyc(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 16'h7777);
    expReq(16'h0000); expInstr(16'h8888, 16'h0000, 16'h0002);
    cyc(1'b0, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 16'h8888);
    cyc(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b1, 16'hBAD0);
    expReq(16'h0002);
    cyc(1'b0, 1'b0, 16'h0, 1'b0, 1'b1, 1'b0, 16'h0);
    cyc(1'b1, 1'b0, 16'h0, 1'b0, 1'b0, 1'b0, 16'h0);

    total++;
    if (reqQ.size() != 0) begin
      bad++;
      $display("FAIL reqDrain: got %0d pending reads expected 0", reqQ.size());
    end
    total++;
    if (instrQ.size() != 0) begin
      bad++;
      $display("FAIL instrDrain: got %0d pending instrs expected 0", instrQ.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
